// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter: mode, preset, carry-in and ovf clear in; count, carry-out and ovf out.
// Latency: n/a (wires only); no backpressure.
interface updown_counter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       mode;
    logic [WIDTH-1:0] preset;
    logic             cin;
    logic             clr_ovf;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;

    modport master (
        output mode, preset, cin, clr_ovf,
        input  out, cout, ovf
    );

    modport slave (
        input  mode, preset, cin, clr_ovf,
        output out, cout, ovf
    );
endinterface

// File: rtl/updown_counter.sv
// Up/down modulo counter 0..MAXVAL with clamped load, cascade carry and sticky ovf; UPDOWN_COUNTER_SATURATE_EN saturates instead of wrapping.
// Latency: out/ovf registered (1 clk), cout combinational; no backpressure, cin is the only count enable.
module updown_counter #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] MAXVAL = {WIDTH{1'b1}}
) (
    input  logic clk,
    input  logic reset,
    updown_counter_if.slave bus
);
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             at_max;
    logic             at_zero;
    logic             count_up;
    logic             count_down;
    logic             term_hit;

    // Anything above MAXVAL is treated as MAXVAL so a corrupted count still terminates.
    assign at_max     = (cnt_q >= MAXVAL);
    assign at_zero    = (cnt_q == '0);
    assign count_up   = bus.cin && (bus.mode == MODE_UP);
    assign count_down = bus.cin && (bus.mode == MODE_DOWN);
    assign term_hit   = (count_up && at_max) || (count_down && at_zero);

    always_comb begin
        cnt_d = cnt_q;
        case (bus.mode)
            MODE_LOAD: cnt_d = (bus.preset > MAXVAL) ? MAXVAL : bus.preset;
            MODE_UP: begin
                if (bus.cin) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    cnt_d = at_max ? MAXVAL : cnt_q + 1'b1;
`else
                    cnt_d = at_max ? '0 : cnt_q + 1'b1;
`endif
                end
            end
            MODE_DOWN: begin
                if (bus.cin) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    cnt_d = at_zero ? '0 : (at_max ? MAXVAL : cnt_q) - 1'b1;
`else
                    cnt_d = at_zero ? MAXVAL : (at_max ? MAXVAL : cnt_q) - 1'b1;
`endif
                end
            end
            MODE_HOLD: cnt_d = cnt_q;
            default:   cnt_d = cnt_q;
        endcase
    end

    // A terminal hit on the same edge as clr_ovf leaves ovf set.
    assign ovf_d = term_hit || (ovf_q && !bus.clr_ovf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out  = cnt_q;
    assign bus.ovf  = ovf_q;
    assign bus.cout = term_hit;
endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter (WIDTH=4, MAXVAL=9): single stage plus a two-digit cascade.
module tb_updown_counter;
    localparam int         W    = 4;
    localparam logic [3:0] MAXV = 4'd9;
`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] out;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   csb[$];
    logic [3:0] m_out;
    logic       m_ovf;

    updown_counter_if #(.WIDTH(W)) bus();
    updown_counter_if #(.WIDTH(W)) bus_lo();
    updown_counter_if #(.WIDTH(W)) bus_hi();

    updown_counter #(.WIDTH(W), .MAXVAL(MAXV)) dut  (.clk(clk), .reset(reset), .bus(bus));
    updown_counter #(.WIDTH(W), .MAXVAL(MAXV)) u_lo (.clk(clk), .reset(reset), .bus(bus_lo));
    updown_counter #(.WIDTH(W), .MAXVAL(MAXV)) u_hi (.clk(clk), .reset(reset), .bus(bus_hi));

    assign bus_hi.mode    = bus_lo.mode;
    assign bus_hi.preset  = bus_lo.preset;
    assign bus_hi.clr_ovf = bus_lo.clr_ovf;
    assign bus_hi.cin     = bus_lo.cout;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Entered at posedge+2; checks cout before the edge and out/ovf 2 ns after it.
    task automatic step(input logic [1:0] m, input logic [3:0] p, input logic c,
                        input logic clr, input string tag);
        logic hit;
        logic exp_cout;
        exp_t e;
        bus.mode    = m;
        bus.preset  = p;
        bus.cin     = c;
        bus.clr_ovf = clr;
        hit      = 1'b0;
        exp_cout = c && ((m == 2'b10 && m_out == MAXV) || (m == 2'b01 && m_out == 4'd0));
        #1;
        chk({tag, ".cout"}, 32'(bus.cout), 32'(exp_cout));
        case (m)
            2'b11: m_out = (p > MAXV) ? MAXV : p;
            2'b10: if (c) begin
                if (m_out == MAXV) begin
                    hit   = 1'b1;
                    m_out = SAT ? MAXV : 4'd0;
                end else m_out = m_out + 4'd1;
            end
            2'b01: if (c) begin
                if (m_out == 4'd0) begin
                    hit   = 1'b1;
                    m_out = SAT ? 4'd0 : MAXV;
                end else m_out = m_out - 4'd1;
            end
            default: ;
        endcase
        m_ovf = hit | (m_ovf & ~clr);
        sb.push_back('{out: m_out, ovf: m_ovf});
        @(posedge clk);
        #2;
        e = sb.pop_front();
        chk({tag, ".out"}, 32'(bus.out), 32'(e.out));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(e.ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        bus.mode       = 2'b00;
        bus.preset     = '0;
        bus.cin        = 1'b0;
        bus.clr_ovf    = 1'b0;
        bus_lo.mode    = 2'b00;
        bus_lo.preset  = '0;
        bus_lo.cin     = 1'b0;
        bus_lo.clr_ovf = 1'b0;
        m_out          = 4'd0;
        m_ovf          = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst.out", 32'(bus.out), 32'd0);
        chk("rst.ovf", 32'(bus.ovf), 32'd0);
        #9 reset = 1'b0;
        @(posedge clk);
        #2;

        for (int i = 0; i < 12; i++) step(2'b10, 4'd0, 1'b1, 1'b0, "up");

        step(2'b00, 4'd0, 1'b0, 1'b1, "clr0");
        step(2'b11, 4'd3, 1'b1, 1'b0, "ld3");
        for (int i = 0; i < 5; i++) step(2'b01, 4'd0, 1'b1, 1'b0, "down");

        step(2'b11, 4'hF, 1'b1, 1'b0, "ldclamp");
        step(2'b11, 4'd2, 1'b0, 1'b0, "ldnocin");
        step(2'b10, 4'd0, 1'b0, 1'b0, "upnocin");

        step(2'b11, 4'd9, 1'b0, 1'b1, "ld9");
        step(2'b10, 4'd0, 1'b1, 1'b1, "setwins");
        step(2'b10, 4'd0, 1'b0, 1'b1, "clr");

        step(2'b11, 4'd9, 1'b0, 1'b0, "ld9b");
        step(2'b10, 4'd0, 1'b1, 1'b0, "wrapb");
        step(2'b11, 4'd7, 1'b0, 1'b0, "ld7");
        bus.mode = 2'b10;
        bus.cin  = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("arst.out", 32'(bus.out), 32'd0);
        chk("arst.ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk);
        #2;
        chk("rsthold.out", 32'(bus.out), 32'd0);
        reset = 1'b0;
        m_out = 4'd0;
        m_ovf = 1'b0;
        step(2'b10, 4'd0, 1'b1, 1'b0, "resume");
        step(2'b10, 4'd0, 1'b1, 1'b0, "resume2");

`ifdef UPDOWN_COUNTER_SATURATE_EN
        step(2'b11, 4'd0, 1'b0, 1'b1, "sld0");
        for (int i = 0; i < 15; i++) step(2'b10, 4'd0, 1'b1, 1'b0, "sat");
        chk("sat.final", 32'(bus.out), 32'(MAXV));
`else
        for (int i = 1; i <= 100; i++) begin
            bus_lo.mode = 2'b10;
            bus_lo.cin  = 1'b1;
            csb.push_back(((i / 10) % 10) * 16 + (i % 10));
            @(posedge clk);
            #2;
            chk("casc", 32'({bus_hi.out, bus_lo.out}), 32'(csb.pop_front()));
            if (i == 99) chk("casc.hicout", 32'(bus_hi.cout), 32'd1);
        end
        chk("casc.hiovf", 32'(bus_hi.ovf), 32'd1);
        chk("casc.loovf", 32'(bus_lo.ovf), 32'd1);
        chk("casc.hicout0", 32'(bus_hi.cout), 32'd0);
        bus_lo.mode = 2'b00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
